// File: rtl/gol_mem_port_arbiter_if.sv
// Bus bundle between the two cell-memory requesters, the arbiter and the
// second port of the Game-of-Life cell memory.
interface gol_mem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              a_req;
  logic              a_write;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;
  logic              a_rdvalid;

  logic              b_req;
  logic              b_write;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;
  logic              b_rdvalid;

  logic              freeze;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  logic [15:0]       a_count;
  logic [15:0]       b_count;

  // Arbiter side
  modport slave (
    input  a_req, a_write, a_addr, a_wdata,
    input  b_req, b_write, b_addr, b_wdata,
    input  freeze, mem_readdata,
    output a_ack, a_rdata, a_rdvalid,
    output b_ack, b_rdata, b_rdvalid,
    output mem_address, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output a_count, b_count
  );

  // Requester / memory side
  modport master (
    output a_req, a_write, a_addr, a_wdata,
    output b_req, b_write, b_addr, b_wdata,
    output freeze, mem_readdata,
    input  a_ack, a_rdata, a_rdvalid,
    input  b_ack, b_rdata, b_rdvalid,
    input  mem_address, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  a_count, b_count
  );
endinterface

// File: rtl/gol_mem_port_arbiter.sv
// Round-robin arbiter with bounded bursts sharing the second cell-memory port
// between the generation engine (A) and the frame scanner (B). The granted
// command is registered onto the port; read data is steered back to its
// owner two cycles after acceptance by a small owner-tag pipeline.
module gol_mem_port_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input logic                  clk,
  input logic                  reset,
  gol_mem_port_arbiter_if.slave bus
);

  typedef enum logic {OWNER_A = 1'b0, OWNER_B = 1'b1} owner_t;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  function automatic logic [3:0] burst_sat_inc(input logic [3:0] b);
    return (b >= BURST_LIM) ? BURST_LIM : b + 4'd1;
  endfunction

  function automatic logic [15:0] count_sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  owner_t              last_owner, last_owner_nxt;
  logic [3:0]          burst_cnt, burst_nxt;
  owner_t              other_owner;
  logic                keep_owner;

  logic                winner_vld;
  owner_t              winner;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  logic                cs_p1, we_p1;
  logic [ADDR_W-1:0]   addr_p1;
  logic [DATA_W-1:0]   wdata_p1;
  logic                rd_vld_p1, rd_vld_p2;
  owner_t              rd_own_p1, rd_own_p2;

  logic [15:0]         a_cnt, b_cnt;

  // burst_cnt == 0 only right after reset: no burst is running, so the
  // first contested cycle goes to the requester that is not last_owner (A).
  assign other_owner = (last_owner == OWNER_A) ? OWNER_B : OWNER_A;
  assign keep_owner  = (burst_cnt != 4'd0) && (burst_cnt < BURST_LIM);

  assign sel_write = (winner == OWNER_A) ? bus.a_write : bus.b_write;
  assign sel_addr  = (winner == OWNER_A) ? bus.a_addr  : bus.b_addr;
  assign sel_wdata = (winner == OWNER_A) ? bus.a_wdata : bus.b_wdata;

  // ---- stage p0: grant decision and next burst state ----
  always_comb begin
    winner_vld     = 1'b0;
    winner         = last_owner;
    last_owner_nxt = last_owner;
    burst_nxt      = burst_cnt;
    if (!reset && !bus.freeze) begin
      case ({bus.a_req, bus.b_req})
        2'b10:   begin winner_vld = 1'b1; winner = OWNER_A; end
        2'b01:   begin winner_vld = 1'b1; winner = OWNER_B; end
        2'b11:   begin winner_vld = 1'b1; winner = keep_owner ? last_owner : other_owner; end
        default: ;
      endcase
    end
    if (winner_vld) begin
      if (winner == last_owner) begin
        burst_nxt = burst_sat_inc(burst_cnt);
      end else begin
        burst_nxt      = 4'd1;
        last_owner_nxt = winner;
      end
    end
  end

  // Arbitration state register
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= OWNER_B;
      burst_cnt  <= 4'd0;
    end else begin
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_nxt;
    end
  end

  // ---- stage p1: registered command on the memory port ----
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_p1     <= 1'b0;
      we_p1     <= 1'b0;
      addr_p1   <= '0;
      wdata_p1  <= '0;
      rd_vld_p1 <= 1'b0;
      rd_own_p1 <= OWNER_A;
    end else begin
      cs_p1     <= winner_vld;
      we_p1     <= winner_vld && sel_write;
      rd_vld_p1 <= winner_vld && !sel_write;
      rd_own_p1 <= winner;
      if (winner_vld) begin
        addr_p1  <= sel_addr;
        wdata_p1 <= sel_wdata;
      end
    end
  end

  // ---- stage p2: owner tag aligned with mem_readdata ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_p2 <= 1'b0;
      rd_own_p2 <= OWNER_A;
    end else begin
      rd_vld_p2 <= rd_vld_p1;
      rd_own_p2 <= rd_own_p1;
    end
  end

  // Per-requester accepted-command counters
  always_ff @(posedge clk) begin
    if (reset) begin
      a_cnt <= 16'd0;
      b_cnt <= 16'd0;
    end else begin
      if (bus.a_ack) a_cnt <= count_sat_inc(a_cnt);
      if (bus.b_ack) b_cnt <= count_sat_inc(b_cnt);
    end
  end

  assign bus.a_ack = winner_vld && (winner == OWNER_A);
  assign bus.b_ack = winner_vld && (winner == OWNER_B);

  // Reset drops the port strobes immediately, not one cycle later.
  assign bus.mem_chipselect = cs_p1 && !reset;
  assign bus.mem_write      = we_p1 && !reset;
  assign bus.mem_address    = addr_p1;
  assign bus.mem_writedata  = wdata_p1;
  assign bus.mem_clken      = 1'b1;

  assign bus.a_rdvalid = rd_vld_p2 && (rd_own_p2 == OWNER_A) && !reset;
  assign bus.b_rdvalid = rd_vld_p2 && (rd_own_p2 == OWNER_B) && !reset;
  assign bus.a_rdata   = bus.a_rdvalid ? bus.mem_readdata : '0;
  assign bus.b_rdata   = bus.b_rdvalid ? bus.mem_readdata : '0;

  assign bus.a_count = a_cnt;
  assign bus.b_count = b_cnt;

endmodule
